sram_a_arbiter: RTL and testbench

// Shares the single-port activation SRAM (1-cycle read latency, write-first

---
 rtl/sram_a_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_sram_a_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_a_arbiter.sv
// ---------------------------------------------------------------------------
// sram_a_arbiter
//
// Shares a single-port activation SRAM (1-cycle read latency) between a host
// port (single reads/writes) and a stream reader that fetches a contiguous
// run of words into a 2-entry skid FIFO for the compute array. This block
// drives every SRAM control pin.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   host_req/we/addr/wdata          host request, held until host_gnt
//   host_gnt                        host access issued this cycle (comb)
//   host_rvalid/host_rdata          host read data, 1 cycle after grant
//   strm_start/base/len             stream start pulse + parameters
//   strm_busy                       stream FSM not idle
//   strm_done                       1-cycle pulse when stream delivered
//   strm_valid/data/ready           stream output handshake
//   sram_ce/we/addr/din/dout        SRAM macro interface
// ---------------------------------------------------------------------------
module sram_a_arbiter #(
    parameter int AW    = 10,
    parameter int DW    = 8,
    parameter int LEN_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             host_req,
    input  logic             host_we,
    input  logic [AW-1:0]    host_addr,
    input  logic [DW-1:0]    host_wdata,
    output logic             host_gnt,
    output logic             host_rvalid,
    output logic [DW-1:0]    host_rdata,
    input  logic             strm_start,
    input  logic [AW-1:0]    strm_base,
    input  logic [LEN_W-1:0] strm_len,
    output logic             strm_busy,
    output logic             strm_done,
    output logic             strm_valid,
    output logic [DW-1:0]    strm_data,
    input  logic             strm_ready,
    output logic             sram_ce,
    output logic             sram_we,
    output logic [AW-1:0]    sram_addr,
    output logic [DW-1:0]    sram_din,
    input  logic [DW-1:0]    sram_dout
);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t           state_reg;
    logic [AW-1:0]    cur_reg;
    logic [LEN_W-1:0] len_reg;
    logic [LEN_W-1:0] issued_reg;
    logic             inflight_reg;      // stream read issued last cycle
    logic             host_rvalid_reg;
    logic             done_zero_reg;     // done pulse for a zero-length start
    logic             rr_last_strm_reg;  // 1 = stream won the last conflict

    // 2-entry skid FIFO
    logic [DW-1:0]    fifo_mem [2];
    logic             wr_ptr_reg;
    logic             rd_ptr_reg;
    logic [1:0]       count_reg;

    logic             pop;
    logic [2:0]       occ_after_pop;
    logic             strm_elig;
    logic             strm_gnt;
    logic             conflict;
    logic             drain_done;

    assign pop = (count_reg != 2'd0) && strm_ready;

    // Occupancy the FIFO will have once the in-flight word lands and the
    // current pop retires; issuing is allowed while that is below 2, so a
    // full-rate consumer keeps one word per cycle flowing.
    assign occ_after_pop = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};

    assign strm_elig = (state_reg == STREAM) && (issued_reg < len_reg) &&
                       (occ_after_pop < 3'd2);

    // On a conflict the side that did not win the previous conflict wins.
    assign conflict = host_req && strm_elig;
    assign host_gnt = host_req && (!strm_elig || rr_last_strm_reg);
    assign strm_gnt = strm_elig && !host_gnt;

    assign sram_ce   = host_gnt || strm_gnt;
    assign sram_we   = host_gnt && host_we;
    assign sram_addr = host_gnt ? host_addr : cur_reg;
    assign sram_din  = host_wdata;

    assign host_rvalid = host_rvalid_reg;
    assign host_rdata  = host_rvalid_reg ? sram_dout : '0;

    assign strm_valid = (count_reg != 2'd0);
    assign strm_data  = strm_valid ? fifo_mem[rd_ptr_reg] : '0;
    assign strm_busy  = (state_reg != IDLE);

    assign drain_done = (state_reg == DRAIN) && (count_reg == 2'd0) && !inflight_reg;
    assign strm_done  = drain_done || done_zero_reg;

    // FIFO storage: written with the SRAM word one cycle after its grant.
    always_ff @(posedge clk) begin
        if (inflight_reg) begin
            fifo_mem[wr_ptr_reg] <= sram_dout;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (inflight_reg) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_reg + {1'b0, inflight_reg} - {1'b0, pop};
        end
    end

    // Arbitration bookkeeping and read-return tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_reg     <= 1'b0;
            host_rvalid_reg  <= 1'b0;
            rr_last_strm_reg <= 1'b1;
        end else begin
            inflight_reg    <= strm_gnt;
            host_rvalid_reg <= host_gnt && !host_we;
            if (conflict) begin
                rr_last_strm_reg <= strm_gnt;
            end
        end
    end

    // Stream FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cur_reg       <= '0;
            len_reg       <= '0;
            issued_reg    <= '0;
            done_zero_reg <= 1'b0;
        end else begin
            done_zero_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (strm_start) begin
                        if (strm_len != '0) begin
                            cur_reg    <= strm_base;
                            len_reg    <= strm_len;
                            issued_reg <= '0;
                            state_reg  <= STREAM;
                        end else begin
                            done_zero_reg <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (strm_gnt) begin
                        // Address wraps naturally modulo 2**AW.
                        cur_reg    <= cur_reg + AW'(1);
                        issued_reg <= issued_reg + LEN_W'(1);
                    end
                    if (issued_reg == len_reg) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_a_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_a_arbiter
//
// Scoreboard bench: stimulus tasks push expected read data into queues; a
// negedge monitor pops and compares whenever host_rvalid or a stream pop is
// presented. A behavioural write-first SRAM model sits on the SRAM pins.
// ---------------------------------------------------------------------------
module tb_sram_a_arbiter;
    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int LEN_W = 11;
    localparam int DEPTH = 1 << AW;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             host_req = 1'b0;
    logic             host_we = 1'b0;
    logic [AW-1:0]    host_addr = '0;
    logic [DW-1:0]    host_wdata = '0;
    logic             host_gnt;
    logic             host_rvalid;
    logic [DW-1:0]    host_rdata;
    logic             strm_start = 1'b0;
    logic [AW-1:0]    strm_base = '0;
    logic [LEN_W-1:0] strm_len = '0;
    logic             strm_busy;
    logic             strm_done;
    logic             strm_valid;
    logic [DW-1:0]    strm_data;
    logic             strm_ready = 1'b1;
    logic             sram_ce;
    logic             sram_we;
    logic [AW-1:0]    sram_addr;
    logic [DW-1:0]    sram_din;
    logic [DW-1:0]    sram_dout = '0;

    sram_a_arbiter #(.AW(AW), .DW(DW), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
        .host_rdata(host_rdata),
        .strm_start(strm_start), .strm_base(strm_base), .strm_len(strm_len),
        .strm_busy(strm_busy), .strm_done(strm_done), .strm_valid(strm_valid),
        .strm_data(strm_data), .strm_ready(strm_ready),
        .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_dout(sram_dout)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: 1-cycle read latency, write-first.
    logic [DW-1:0] smem [DEPTH];
    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_we) begin
                smem[sram_addr] <= sram_din;
                sram_dout       <= sram_din;
            end else begin
                sram_dout <= smem[sram_addr];
            end
        end
    end

    // Bench-side expected memory contents.
    logic [DW-1:0] shadow [DEPTH];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [DW-1:0]  exp_host[$];
    logic [DW-1:0]  exp_strm[$];
    logic [AW-1:0]  addr_q[$];
    int pop_count     = 0;
    int first_pop_cyc = 0;
    int last_pop_cyc  = 0;
    int done_count    = 0;
    int outstanding   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: 0x%0h (cycle %0d)", name, act, cyc);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            outstanding = 0;
        end else begin
            if (host_rvalid) begin
                if (exp_host.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL host_rvalid_unexpected: got rdata 0x%0h expected no rvalid", host_rdata);
                end else begin
                    chk("host_rdata", host_rdata, exp_host.pop_front());
                end
            end
            if (strm_valid && strm_ready) begin
                if (exp_strm.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL strm_pop_unexpected: got data 0x%0h expected no pop", strm_data);
                end else begin
                    chk("strm_data", strm_data, exp_strm.pop_front());
                end
                if (pop_count == 0) first_pop_cyc = cyc;
                last_pop_cyc = cyc;
                pop_count++;
                outstanding--;
            end
            if (sram_ce && !host_gnt) begin
                addr_q.push_back(sram_addr);
                outstanding++;
            end
            // Words granted but not yet consumed must fit in the skid FIFO.
            n_checks++;
            if (outstanding > 2) begin
                n_fail++;
                $display("FAIL fifo_overflow: got outstanding %0d expected <= 2", outstanding);
            end
            if (strm_done) done_count++;
        end
    end

    task automatic host_op(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           output int waited);
        @(posedge clk); #1;
        host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
        if (we) shadow[a] = d;
        else    exp_host.push_back(shadow[a]);
        waited = 0;
        @(negedge clk);
        while (!host_gnt && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (waited >= 20) begin
            n_checks++; n_fail++;
            $display("FAIL host_gnt_timeout: got no grant expected grant within 20 cycles");
        end
        @(posedge clk); #1;
        host_req = 1'b0;
        @(negedge clk);
        chk(we ? "host_wr_no_rvalid" : "host_rd_rvalid", 32'(host_rvalid), 32'(!we));
    endtask

    task automatic host_burst(input int n, input logic [AW-1:0] base);
        int waited;
        @(posedge clk); #1;
        host_req = 1'b1; host_we = 1'b0;
        for (int i = 0; i < n; i++) begin
            host_addr = base + AW'(i);
            exp_host.push_back(shadow[host_addr]);
            waited = 0;
            @(negedge clk);
            while (!host_gnt && waited < 20) begin
                waited++;
                @(negedge clk);
            end
            chk("burst_host_wait_le1", 32'(waited <= 1), 32'd1);
            @(posedge clk); #1;
        end
        host_req = 1'b0;
    endtask

    task automatic strm_go(input logic [AW-1:0] base, input logic [LEN_W-1:0] len);
        @(posedge clk); #1;
        strm_start = 1'b1; strm_base = base; strm_len = len;
        for (int i = 0; i < int'(len); i++) exp_strm.push_back(shadow[base + AW'(i)]);
        @(posedge clk); #1;
        strm_start = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int dcyc);
        int k = 0;
        @(negedge clk);
        while (!strm_done && k < bound) begin
            k++;
            @(negedge clk);
        end
        if (k >= bound) begin
            n_checks++; n_fail++;
            $display("FAIL strm_done_timeout: got no done expected done within %0d cycles", bound);
        end
        dcyc = cyc;
    endtask

    initial begin
        int w;
        int dcyc;
        int dc0;
        logic [AW-1:0] exp_addr [4];
        exp_addr[0] = 10'h3FE; exp_addr[1] = 10'h3FF; exp_addr[2] = 10'h000; exp_addr[3] = 10'h001;

        for (int i = 0; i < DEPTH; i++) begin
            smem[i]   = DW'(i * 37 + 11);
            shadow[i] = DW'(i * 37 + 11);
        end

        // Reset state
        #12;
        chk("rst_busy", 32'(strm_busy), 0);
        chk("rst_valid", 32'(strm_valid), 0);
        chk("rst_done", 32'(strm_done), 0);
        chk("rst_rvalid", 32'(host_rvalid), 0);
        chk("rst_ce", 32'(sram_ce), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // 1: host write then read back
        host_op(1'b1, 10'h010, 8'h5A, w);
        chk("t1_wr_wait", 32'(w), 0);
        host_op(1'b0, 10'h010, 8'h00, w);
        chk("t1_rd_wait", 32'(w), 0);

        // 2: stream base 0, len 8, full-rate consumer
        pop_count = 0;
        strm_go(10'h000, 11'd8);
        wait_done(100, dcyc);
        chk("t2_pops", 32'(pop_count), 8);
        chk("t2_consecutive", 32'(last_pop_cyc - first_pop_cyc), 7);
        chk("t2_done_latency", 32'(dcyc - last_pop_cyc), 1);
        @(negedge clk);
        chk("t2_done_pulse_1cyc", 32'(strm_done), 0);
        chk("t2_busy_after", 32'(strm_busy), 0);

        // 3: stream len 16 with host held continuously
        pop_count = 0;
        strm_go(10'h200, 11'd16);
        fork
            host_burst(12, 10'h100);
            wait_done(200, dcyc);
        join
        chk("t3_pops", 32'(pop_count), 16);

        // 4: address wrap
        addr_q.delete();
        strm_go(10'h3FE, 11'd4);
        wait_done(100, dcyc);
        chk("t4_addr_count", 32'(addr_q.size()), 4);
        for (int i = 0; i < 4 && i < addr_q.size(); i++) chk("t4_addr", 32'(addr_q[i]), 32'(exp_addr[i]));

        // 5: back-pressure
        pop_count = 0;
        strm_go(10'h040, 11'd6);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1 strm_ready = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1 strm_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i >= 3) chk("t5_ce_idle_stalled", 32'(sram_ce), 0);
        end
        dc0 = done_count;
        for (int i = 0; i < 300 && done_count == dc0; i++) begin
            @(posedge clk); #1 strm_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        strm_ready = 1'b1;
        chk("t5_done_seen", 32'(done_count - dc0), 1);
        chk("t5_pops", 32'(pop_count), 6);

        // 6: reset mid-stream, restart, zero-length start
        strm_go(10'h080, 11'd20);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(strm_valid), 0);
        chk("t6_rst_busy", 32'(strm_busy), 0);
        chk("t6_rst_done", 32'(strm_done), 0);
        chk("t6_rst_ce", 32'(sram_ce), 0);
        exp_strm.delete();
        dc0 = done_count;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("t6_no_done_after_rst", 32'(done_count - dc0), 0);
        pop_count = 0;
        strm_go(10'h020, 11'd3);
        wait_done(100, dcyc);
        chk("t6_restart_pops", 32'(pop_count), 3);
        strm_go(10'h000, 11'd0);
        @(negedge clk);
        chk("t6_len0_done", 32'(strm_done), 1);
        chk("t6_len0_busy", 32'(strm_busy), 0);
        @(negedge clk);
        chk("t6_len0_done_pulse", 32'(strm_done), 0);

        repeat (3) @(negedge clk);
        chk("end_strm_queue_empty", 32'(exp_strm.size()), 0);
        chk("end_host_queue_empty", 32'(exp_host.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish before 2ms");
        $fatal(1, "timeout");
    end
endmodule
